// File: rtl/prach_deconv_if.sv
// Sample, configuration and result signals of the PRACH de-rotator.
// The master drives samples and FCW writes; the slave (the de-rotator) returns results.
interface prach_deconv_if #(parameter int PHASE_W = 24);
  logic signed [15:0]  din_dr, din_di;
  logic                din_dv;
  logic [7:0]          din_chn;
  logic                sync_in;
  logic                cfg_wr;
  logic [7:0]          cfg_chn;
  logic [PHASE_W-1:0]  cfg_fcw;
  logic signed [15:0]  dout_dr, dout_di;
  logic                dout_dv;
  logic [7:0]          dout_chn;
  logic                sync_out;
  logic                err_ovf;

  modport master (
    output din_dr, din_di, din_dv, din_chn, sync_in, cfg_wr, cfg_chn, cfg_fcw,
    input  dout_dr, dout_di, dout_dv, dout_chn, sync_out, err_ovf
  );

  modport slave (
    input  din_dr, din_di, din_dv, din_chn, sync_in, cfg_wr, cfg_chn, cfg_fcw,
    output dout_dr, dout_di, dout_dv, dout_chn, sync_out, err_ovf
  );
endinterface

// File: rtl/prach_deconv.sv
// Per-channel NCO de-rotator: multiplies each sample by e^(-j*theta), 8-cycle latency.
// Build option PRACH_DECONV_ROUND_EN selects round-half-up instead of floor before saturation.

module prach_deconv_chn #(
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hit,
  input  logic               sync,
  input  logic               wr,
  input  logic [PHASE_W-1:0] wr_fcw,
  output logic [11:0]        phs
);
  logic [PHASE_W-1:0] acc, fcw;

  // The accumulator update reads the pre-write fcw, so a same-cycle write applies from the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      fcw <= '0;
    end else begin
      if (sync)     acc <= hit ? fcw : '0;
      else if (hit) acc <= acc + fcw;
      if (wr)       fcw <= wr_fcw;
    end
  end

  assign phs = acc[PHASE_W-1 -: 12];
endmodule

module prach_deconv #(
  parameter int NUM_CHN = 8,
  parameter int PHASE_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  prach_deconv_if.slave  bus
);
  localparam int  STAGES = 8;
  localparam real PI     = 3.14159265358979323846;

  logic [NUM_CHN-1:0]       hit, wr;
  logic [NUM_CHN-1:0][11:0] phs;
  logic [11:0]              p_sel;

  for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
    assign hit[c] = bus.din_dv && (bus.din_chn == 8'(c));
    assign wr[c]  = bus.cfg_wr && (bus.cfg_chn == 8'(c));
    prach_deconv_chn #(.PHASE_W(PHASE_W)) u_chn (
      .clk    (clk),
      .rst_n  (rst_n),
      .hit    (hit[c]),
      .sync   (bus.sync_in),
      .wr     (wr[c]),
      .wr_fcw (bus.cfg_fcw),
      .phs    (phs[c])
    );
  end

  // Out-of-range channels, idle cycles and sync cycles all see theta = 0.
  always_comb begin
    p_sel = '0;
    for (int c = 0; c < NUM_CHN; c++)
      if (hit[c] && !bus.sync_in) p_sel = phs[c];
  end

  // Quarter-wave cosine table, 0..90 degrees inclusive; other quadrants by symmetry.
  logic [14:0] qrom [0:1024];
  for (genvar i = 0; i <= 1024; i++) begin : g_rom
    localparam real         ANG = 2.0 * PI * $itor(i) / 4096.0;
    localparam logic [14:0] VAL = 15'($rtoi(16384.0 * $cos(ANG) + 0.5));
    assign qrom[i] = VAL;
  end

  logic [STAGES:1]       vld_pipe, sync_pipe;
  logic [STAGES:1][7:0]  chn_pipe;

  logic [11:0]         s1_p;
  logic signed [15:0]  s1_dr, s1_di, s2_dr, s2_di, s2_cos, s2_sin;
  logic signed [31:0]  s3_rc, s3_is, s3_ic, s3_rs;
  logic signed [32:0]  s4_pr, s4_pi, s5_pr, s5_pi, s6_pr, s6_pi;
  logic signed [15:0]  s7_dr, s7_di, o_dr, o_di;
  logic                s7_ovf, err;

  logic [1:0]          quad;
  logic [9:0]          qidx;
  logic signed [15:0]  ra, rb, rom_cos, rom_sin;

  assign quad = s1_p[11:10];
  assign qidx = s1_p[9:0];
  assign ra   = {1'b0, qrom[qidx]};
  assign rb   = {1'b0, qrom[11'd1024 - {1'b0, qidx}]};

  always_comb begin
    rom_cos = ra;
    rom_sin = rb;
    case (quad)
      2'd1:    begin rom_cos = -rb; rom_sin =  ra; end
      2'd2:    begin rom_cos = -ra; rom_sin = -rb; end
      2'd3:    begin rom_cos =  rb; rom_sin = -ra; end
      default: begin rom_cos =  ra; rom_sin =  rb; end
    endcase
  end

  // Returns {saturated, value} after the >>>14 scaling.
  function automatic logic [16:0] scale_sat(input logic signed [32:0] v);
    logic signed [32:0] r;
`ifdef PRACH_DECONV_ROUND_EN
    r = v + 33'sd8192;
`else
    r = v;
`endif
    r = r >>> 14;
    if (r > 33'sd32767)       return {1'b1, 16'h7fff};
    else if (r < -33'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, r[15:0]};
  endfunction

  logic [16:0] sat_r, sat_i;
  assign sat_r = scale_sat(s6_pr);
  assign sat_i = scale_sat(s6_pi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      sync_pipe <= '0;
      chn_pipe  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], bus.din_dv};
      sync_pipe <= {sync_pipe[STAGES-1:1], bus.sync_in};
      chn_pipe  <= {chn_pipe[STAGES-1:1], bus.din_chn};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p   <= '0; s1_dr  <= '0; s1_di  <= '0;
      s2_dr  <= '0; s2_di  <= '0; s2_cos <= '0; s2_sin <= '0;
      s3_rc  <= '0; s3_is  <= '0; s3_ic  <= '0; s3_rs  <= '0;
      s4_pr  <= '0; s4_pi  <= '0; s5_pr  <= '0; s5_pi  <= '0;
      s6_pr  <= '0; s6_pi  <= '0;
      s7_dr  <= '0; s7_di  <= '0; s7_ovf <= 1'b0;
      o_dr   <= '0; o_di   <= '0; err    <= 1'b0;
    end else begin
      s1_p   <= p_sel;
      s1_dr  <= bus.din_dr;
      s1_di  <= bus.din_di;
      s2_dr  <= s1_dr;
      s2_di  <= s1_di;
      s2_cos <= rom_cos;
      s2_sin <= rom_sin;
      s3_rc  <= 32'(s2_dr) * 32'(s2_cos);
      s3_is  <= 32'(s2_di) * 32'(s2_sin);
      s3_ic  <= 32'(s2_di) * 32'(s2_cos);
      s3_rs  <= 32'(s2_dr) * 32'(s2_sin);
      s4_pr  <= 33'(s3_rc) + 33'(s3_is);
      s4_pi  <= 33'(s3_ic) - 33'(s3_rs);
      // Two register stages of slack after the adders for multiplier retiming.
      s5_pr  <= s4_pr;
      s5_pi  <= s4_pi;
      s6_pr  <= s5_pr;
      s6_pi  <= s5_pi;
      s7_dr  <= sat_r[15:0];
      s7_di  <= sat_i[15:0];
      s7_ovf <= sat_r[16] | sat_i[16];
      o_dr   <= s7_dr;
      o_di   <= s7_di;
      if (vld_pipe[7] && s7_ovf) err <= 1'b1;
    end
  end

  assign bus.dout_dr  = o_dr;
  assign bus.dout_di  = o_di;
  assign bus.dout_dv  = vld_pipe[STAGES];
  assign bus.dout_chn = chn_pipe[STAGES];
  assign bus.sync_out = sync_pipe[STAGES];
  assign bus.err_ovf  = err;
endmodule

// File: tb/tb_prach_deconv.sv
// Directed + random bench for prach_deconv against a phase/trig reference model.
module tb_prach_deconv;
  localparam int  NUM_CHN = 8;
  localparam int  PHASE_W = 24;
  localparam int  MASK    = (1 << PHASE_W) - 1;
  localparam real PI      = 3.14159265358979323846;
`ifdef PRACH_DECONV_ROUND_EN
  localparam bit  RND = 1'b1;
`else
  localparam bit  RND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  prach_deconv_if #(.PHASE_W(PHASE_W)) bus();

  prach_deconv #(.NUM_CHN(NUM_CHN), .PHASE_W(PHASE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit dv; int dr; int di; int chn; bit sync; bit sat;
    bit fix; int fdr; int fdi; int fsy;
  } exp_t;

  exp_t q[$];
  int   acc_m [NUM_CHN];
  int   fcw_m [NUM_CHN];
  bit   err_m;
  int   checks, errors;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int scale(input int v, output bit s);
    int y;
    y = $rtoi($floor($itor(v) / 16384.0 + (RND ? 0.5 : 0.0)));
    s = 1'b0;
    if (y > 32767)  begin y = 32767;  s = 1'b1; end
    if (y < -32768) begin y = -32768; s = 1'b1; end
    return y;
  endfunction

  // theta -> conjugate rotation using real trig, Q1.14 phasor rounded to nearest.
  task automatic model_out(input int th, input int dr, input int di,
                           output int yr, output int yi, output bit sat);
    int p, c, s, pr, pi;
    bit sr, si;
    real ang;
    p   = th >> (PHASE_W - 12);
    ang = 2.0 * PI * $itor(p) / 4096.0;
    c   = $rtoi($floor(16384.0 * $cos(ang) + 0.5));
    s   = $rtoi($floor(16384.0 * $sin(ang) + 0.5));
    pr  = dr * c + di * s;
    pi  = di * c - dr * s;
    yr  = scale(pr, sr);
    yi  = scale(pi, si);
    sat = sr | si;
  endtask

  task automatic tick(input bit fix, input int fdr, input int fdi, input int fsy);
    exp_t e;
    bit   hit;
    int   th, ch;
    ch  = int'(bus.din_chn);
    hit = (bus.din_dv === 1'b1) && (ch < NUM_CHN);
    th  = (hit && !bus.sync_in) ? acc_m[ch] : 0;
    model_out(th, int'(bus.din_dr), int'(bus.din_di), e.dr, e.di, e.sat);
    e.dv = bus.din_dv; e.chn = ch; e.sync = bus.sync_in;
    e.fix = fix; e.fdr = fdr; e.fdi = fdi; e.fsy = fsy;
    if (bus.sync_in) begin
      for (int c = 0; c < NUM_CHN; c++) acc_m[c] = 0;
      if (hit) acc_m[ch] = fcw_m[ch];
    end else if (hit) begin
      acc_m[ch] = (acc_m[ch] + fcw_m[ch]) & MASK;
    end
    if (bus.cfg_wr && int'(bus.cfg_chn) < NUM_CHN) fcw_m[bus.cfg_chn] = int'(bus.cfg_fcw);
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 8) begin
      e = q.pop_front();
      if (e.dv) err_m |= e.sat;
      chk("dout_dv", bus.dout_dv, e.dv);
      chk("dout_chn", bus.dout_chn, e.chn);
      chk("sync_out", bus.sync_out, e.sync);
      chk("err_ovf", bus.err_ovf, err_m);
      if (e.dv) begin
        chk("dout_dr", bus.dout_dr, e.dr);
        chk("dout_di", bus.dout_di, e.di);
      end
      if (e.fix) begin
        chk("fixed_dr", bus.dout_dr, e.fdr);
        chk("fixed_di", bus.dout_di, e.fdi);
        chk("fixed_sync", bus.sync_out, e.fsy);
      end
    end
  endtask

  task automatic smp(input int dr, input int di, input int chn, input bit sy,
                     input bit fix, input int fdr, input int fdi);
    bus.din_dv = 1'b1; bus.din_dr = 16'(dr); bus.din_di = 16'(di);
    bus.din_chn = 8'(chn); bus.sync_in = sy; bus.cfg_wr = 1'b0;
    tick(fix, fdr, fdi, int'(sy));
  endtask

  task automatic idle();
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.cfg_wr = 1'b0;
    tick(1'b0, 0, 0, 0);
  endtask

  task automatic sync_pulse();
    bus.din_dv = 1'b0; bus.sync_in = 1'b1; bus.cfg_wr = 1'b0;
    tick(1'b0, 0, 0, 0);
  endtask

  task automatic cfg(input int chn, input int fcw);
    bus.din_dv = 1'b0; bus.sync_in = 1'b0;
    bus.cfg_wr = 1'b1; bus.cfg_chn = 8'(chn); bus.cfg_fcw = 24'(fcw);
    tick(1'b0, 0, 0, 0);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.cfg_wr = 1'b0;
    #1;
    chk("rst_dout_dr", bus.dout_dr, 0);
    chk("rst_dout_di", bus.dout_di, 0);
    chk("rst_dout_dv", bus.dout_dv, 0);
    chk("rst_dout_chn", bus.dout_chn, 0);
    chk("rst_sync_out", bus.sync_out, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    q.delete();
    for (int c = 0; c < NUM_CHN; c++) begin acc_m[c] = 0; fcw_m[c] = 0; end
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    z = '{dv: 1'b0, dr: 0, di: 0, chn: 0, sync: 1'b0, sat: 1'b0,
          fix: 1'b0, fdr: 0, fdi: 0, fsy: 0};
    repeat (7) q.push_back(z);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.din_dr = '0; bus.din_di = '0; bus.din_dv = 1'b0; bus.din_chn = '0;
    bus.sync_in = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_chn = '0; bus.cfg_fcw = '0;
    #12;
    do_reset();

    // pass-through with all fcw = 0
    smp(1234, -567, 3, 1'b0, 1'b1, 1234, -567);
    repeat (8) idle();

    // quarter-turn
    cfg(0, 1 << 22);
    sync_pulse();
    smp(1000, 0, 0, 1'b0, 1'b1, 1000, 0);
    smp(1000, 0, 0, 1'b0, 1'b1, 0, -1000);
    smp(1000, 0, 0, 1'b0, 1'b1, -1000, 0);
    smp(1000, 0, 0, 1'b0, 1'b1, 0, 1000);

    // interleaved channels 0/1
    cfg(1, 0);
    sync_pulse();
    for (int k = 0; k < 4; k++) begin
      smp(1000, 0, 0, 1'b0, 1'b1, (k == 0) ? 1000 : (k == 2) ? -1000 : 0,
          (k == 1) ? -1000 : (k == 3) ? 1000 : 0);
      smp(1000, 0, 1, 1'b0, 1'b1, 1000, 0);
    end

    // sync mid-stream
    sync_pulse();
    repeat (3) smp(1000, 0, 0, 1'b0, 1'b0, 0, 0);
    smp(1000, 0, 0, 1'b1, 1'b1, 1000, 0);
    smp(1000, 0, 0, 1'b0, 1'b1, 0, -1000);
    repeat (8) idle();

    // fcw write coinciding with a sample on the same channel
    sync_pulse();
    bus.din_dv = 1'b1; bus.din_dr = 16'sd1000; bus.din_di = 16'sd0; bus.din_chn = 8'd2;
    bus.sync_in = 1'b0; bus.cfg_wr = 1'b1; bus.cfg_chn = 8'd2; bus.cfg_fcw = 24'h400000;
    tick(1'b1, 1000, 0, 0);
    smp(1000, 0, 2, 1'b0, 1'b1, 1000, 0);
    smp(1000, 0, 2, 1'b0, 1'b1, 0, -1000);

    // out-of-range channel passes unrotated; out-of-range cfg ignored
    cfg(12, 1 << 20);
    smp(500, -700, 9, 1'b0, 1'b1, 500, -700);
    repeat (8) idle();
    chk("err_before_sat", bus.err_ovf, 0);

    // saturation at 45 degrees
    cfg(0, 1 << 21);
    sync_pulse();
    smp(32767, 32767, 0, 1'b0, 1'b0, 0, 0);
    smp(32767, 32767, 0, 1'b0, 1'b1, 32767, 0);
    repeat (8) idle();
    chk("err_sticky", bus.err_ovf, 1);

    // rounding mode at 45 degrees
    sync_pulse();
    smp(1, 0, 0, 1'b0, 1'b0, 0, 0);
    smp(1, 0, 0, 1'b0, 1'b1, RND ? 1 : 0, -1);
    sync_pulse();
    smp(3, 0, 0, 1'b0, 1'b0, 0, 0);
    smp(3, 0, 0, 1'b0, 1'b1, 2, RND ? -2 : -3);
    repeat (8) idle();
    chk("err_still_set", bus.err_ovf, 1);

    // random traffic
    for (int c = 0; c < NUM_CHN; c++) cfg(c, int'($urandom) & MASK);
    for (int n = 0; n < 500; n++) begin
      bus.din_dv  = ($urandom_range(0, 3) != 0);
      bus.din_dr  = 16'($urandom);
      bus.din_di  = 16'($urandom);
      bus.din_chn = 8'($urandom_range(0, 9));
      bus.sync_in = ($urandom_range(0, 49) == 0);
      bus.cfg_wr  = ($urandom_range(0, 19) == 0);
      bus.cfg_chn = 8'($urandom_range(0, 11));
      bus.cfg_fcw = 24'($urandom);
      tick(1'b0, 0, 0, 0);
    end

    // reset mid-stream, then resume
    do_reset();
    cfg(5, 1 << 22);
    for (int n = 0; n < 40; n++) begin
      bus.din_dv  = 1'b1;
      bus.din_dr  = 16'($urandom_range(0, 8000));
      bus.din_di  = 16'($urandom_range(0, 8000));
      bus.din_chn = 8'($urandom_range(4, 6));
      bus.sync_in = 1'b0;
      bus.cfg_wr  = 1'b0;
      tick(1'b0, 0, 0, 0);
    end
    repeat (8) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
